// File: rtl/uart_tx_buf.sv
// UART transmitter with a small transmit FIFO. Words are serialised LSB-first
// on tx_o at Oversample ticks per bit, frames chained back-to-back from the FIFO.
module uart_tx_buf #(
  parameter int DataWidth    = 8,
  parameter int Oversample   = 16,
  parameter int StopBitTicks = 16,
  parameter int ParityEn     = 0,
  parameter int ParityOdd    = 0,
  parameter int FifoDepth    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sample_tick_i,
  input  logic [DataWidth-1:0]           din_i,
  input  logic                           din_valid_i,
  output logic                           din_ready_o,
  output logic [$clog2(FifoDepth):0]     fifo_count_o,
  output logic                           tx_o,
  output logic                           busy_o,
  output logic                           tx_done_tick_o
);

  localparam int PtrW    = $clog2(FifoDepth);
  localparam int CntW    = PtrW + 1;
  localparam int TickMax = (Oversample > StopBitTicks) ? Oversample : StopBitTicks;
  localparam int TickW   = $clog2(TickMax);
  localparam int BitW    = $clog2(DataWidth);

  localparam logic [TickW-1:0] OsLast   = TickW'(Oversample - 1);
  localparam logic [TickW-1:0] StopLast = TickW'(StopBitTicks - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO
  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push, load;

  assign din_ready_o  = (count_q < CntW'(FifoDepth));
  assign fifo_count_o = count_q;
  assign push         = din_valid_i && din_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

  always_comb begin
    count_d = count_q;
    if (push && !load)      count_d = count_q + CntW'(1);
    else if (!push && load) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Transmit FSM
  logic [2:0]           state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line, done, have;
  logic                 tx_q;

  assign have = (count_q != '0);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    done    = 1'b0;
    line    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (have) load = 1'b1;
      end
      S_START: begin
        line = 1'b0;
        if (sample_tick_i) begin
          if (tick_q == OsLast) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end else tick_d = tick_q + TickW'(1);
        end
      end
      S_DATA: begin
        line = shift_q[0];
        if (sample_tick_i) begin
          if (tick_q == OsLast) begin
            shift_d = shift_q >> 1;
            tick_d  = '0;
            bit_d   = bit_q + BitW'(1);
            if (bit_q == BitLast) state_d = (ParityEn != 0) ? S_PARITY : S_STOP;
          end else tick_d = tick_q + TickW'(1);
        end
      end
      S_PARITY: begin
        line = par_q;
        if (sample_tick_i) begin
          if (tick_q == OsLast) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else tick_d = tick_q + TickW'(1);
        end
      end
      S_STOP: begin
        if (sample_tick_i) begin
          if (tick_q == StopLast) begin
            done   = 1'b1;
            tick_d = '0;
            // Chain straight into the next start bit when more data is queued
            if (have) load = 1'b1;
            else state_d = S_IDLE;
          end else tick_d = tick_q + TickW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      shift_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ (ParityOdd != 0);
      tick_d  = '0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= line;
    end
  end

  assign tx_o           = tx_q;
  assign busy_o         = (state_q != S_IDLE);
  assign tx_done_tick_o = done;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: three configurations (8N1, 8E with 1.5 stop,
// 5-bit odd parity) decoded by tick-counting receiver task.
module tb_uart_tx_buf;

  logic clk, rst, tick, tick_en;
  int   cyc;
  logic [2:0] vld;
  logic [7:0] din0, din1;
  logic [4:0] din2;
  logic [2:0] tx_w, busy_w, done_w, rdy_w;
  logic [2:0][2:0] cnt_w;

  int checks = 0;
  int failures = 0;

  uart_tx_buf u0 (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .din_i(din0), .din_valid_i(vld[0]),
    .din_ready_o(rdy_w[0]), .fifo_count_o(cnt_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]),
    .tx_done_tick_o(done_w[0]));

  uart_tx_buf #(.ParityEn(1), .ParityOdd(0), .StopBitTicks(24)) u1 (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .din_i(din1), .din_valid_i(vld[1]),
    .din_ready_o(rdy_w[1]), .fifo_count_o(cnt_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]),
    .tx_done_tick_o(done_w[1]));

  uart_tx_buf #(.DataWidth(5), .ParityEn(1), .ParityOdd(1)) u2 (
    .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .din_i(din2), .din_valid_i(vld[2]),
    .din_ready_o(rdy_w[2]), .fifo_count_o(cnt_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]),
    .tx_done_tick_o(done_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every 4th clock while enabled, changed just after the rising edge
  initial begin
    tick = 1'b0;
    cyc  = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = tick_en && (cyc % 4 == 0);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int u, input logic [7:0] d);
    int g = 0;
    @(negedge clk);
    while (!rdy_w[u] && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("push_ready", {31'd0, rdy_w[u]}, 32'd1);
    case (u)
      0:       din0 = d;
      1:       din1 = d;
      default: din2 = d[4:0];
    endcase
    vld[u] = 1'b1;
    @(negedge clk);
    vld[u] = 1'b0;
  endtask

  // Counts frame ticks (tick presented while busy); samples mid-bit and stops on done
  task automatic rx_frame(input int u, input int nb, input int pe, input int stop,
                          output logic [7:0] data, output logic pbit, output int nticks,
                          output logic start_l, output logic stop_l);
    int n = 0;
    int g = 0;
    int k;
    data = '0; pbit = 1'bx; nticks = -1; start_l = 1'bx; stop_l = 1'bx;
    while (g < 4000) begin
      @(negedge clk);
      g++;
      if (tick && busy_w[u]) begin
        n++;
        if (n >= 8 && (n - 8) % 16 == 0) begin
          k = (n - 8) / 16;
          if (k == 0) start_l = tx_w[u];
          else if (k <= nb) data[k-1] = tx_w[u];
          else if (pe != 0 && k == nb + 1) pbit = tx_w[u];
        end
        if (n == 16 * (1 + nb + pe) + stop / 2) stop_l = tx_w[u];
        if (done_w[u]) begin
          nticks = n;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic p, sl, el;
    int n, g, bad;
    rst = 1'b1; vld = '0; din0 = '0; din1 = '0; din2 = '0; tick_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("rst_busy", {29'd0, busy_w}, 32'd0);
    chk("rst_done", {29'd0, done_w}, 32'd0);
    chk("rst_ready", {29'd0, rdy_w}, 32'd7);
    chk("rst_count", {29'd0, cnt_w[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx", {29'd0, tx_w}, 32'd7);

    // 8N1 0xA5
    push(0, 8'hA5);
    tick_en = 1'b1;
    rx_frame(0, 8, 0, 16, d, p, n, sl, el);
    tick_en = 1'b0;
    chk("a5_data", {24'd0, d}, 32'hA5);
    chk("a5_start", {31'd0, sl}, 32'd0);
    chk("a5_stop", {31'd0, el}, 32'd1);
    chk("a5_ticks", n, 32'd160);
    @(negedge clk);
    chk("a5_idle_busy", {31'd0, busy_w[0]}, 32'd0);

    // Even parity, 1.5 stop bits, back-to-back
    push(1, 8'h07);
    push(1, 8'hC3);
    tick_en = 1'b1;
    rx_frame(1, 8, 1, 24, d, p, n, sl, el);
    chk("par07_data", {24'd0, d}, 32'h07);
    chk("par07_bit", {31'd0, p}, 32'd1);
    chk("par07_stop", {31'd0, el}, 32'd1);
    chk("par07_ticks", n, 32'd184);
    @(negedge clk);
    @(negedge clk);
    chk("stop24_next_start", {31'd0, tx_w[1]}, 32'd0);
    rx_frame(1, 8, 1, 24, d, p, n, sl, el);
    tick_en = 1'b0;
    chk("parc3_data", {24'd0, d}, 32'hC3);
    chk("parc3_bit", {31'd0, p}, 32'd0);
    chk("parc3_ticks", n, 32'd184);

    // Five data bits, odd parity
    push(2, 8'h1F);
    tick_en = 1'b1;
    rx_frame(2, 5, 1, 16, d, p, n, sl, el);
    tick_en = 1'b0;
    chk("w5_data", {24'd0, d}, 32'h1F);
    chk("w5_odd_bit", {31'd0, p}, 32'd0);
    chk("w5_ticks", n, 32'd128);

    // Ticks held low: line frozen in start bit, pushes still accepted
    push(0, 8'h5A);
    push(0, 8'h77);
    repeat (40) @(negedge clk);
    chk("frz_tx", {31'd0, tx_w[0]}, 32'd0);
    chk("frz_busy", {31'd0, busy_w[0]}, 32'd1);
    chk("frz_count", {29'd0, cnt_w[0]}, 32'd1);
    tick_en = 1'b1;
    rx_frame(0, 8, 0, 16, d, p, n, sl, el);
    chk("frz5a_data", {24'd0, d}, 32'h5A);
    chk("frz5a_ticks", n, 32'd160);
    @(negedge clk);
    @(negedge clk);
    rx_frame(0, 8, 0, 16, d, p, n, sl, el);
    tick_en = 1'b0;
    chk("frz77_data", {24'd0, d}, 32'h77);

    // Fill FIFO, sixth word waits on ready, six frames with no gap
    for (int i = 0; i < 5; i++) push(0, 8'h11 + 8'(i));
    chk("full_count", {29'd0, cnt_w[0]}, 32'd4);
    chk("full_ready", {31'd0, rdy_w[0]}, 32'd0);
    tick_en = 1'b1;
    fork
      push(0, 8'h16);
      begin
        for (int f = 0; f < 6; f++) begin
          logic [7:0] fd;
          logic fp, fs, fe;
          int fn;
          rx_frame(0, 8, 0, 16, fd, fp, fn, fs, fe);
          chk("b2b_data", {24'd0, fd}, 32'h11 + f);
          chk("b2b_ticks", fn, 32'd160);
          @(negedge clk);
          if (f < 5) begin
            chk("b2b_busy_hold", {31'd0, busy_w[0]}, 32'd1);
            @(negedge clk);
            chk("b2b_start_low", {31'd0, tx_w[0]}, 32'd0);
          end else begin
            chk("b2b_busy_fall", {31'd0, busy_w[0]}, 32'd0);
            chk("b2b_count0", {29'd0, cnt_w[0]}, 32'd0);
          end
        end
      end
    join
    tick_en = 1'b0;

    // Reset during data bit 3 (a zero bit) with two words queued
    push(0, 8'h33);
    push(0, 8'h44);
    push(0, 8'h55);
    chk("mid_count", {29'd0, cnt_w[0]}, 32'd2);
    tick_en = 1'b1;
    n = 0;
    g = 0;
    while (n < 72 && g < 2000) begin
      @(negedge clk);
      g++;
      if (tick && busy_w[0]) n++;
    end
    chk("mid_reached", n, 32'd72);
    chk("mid_tx_low", {31'd0, tx_w[0]}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("mid_rst_count", {29'd0, cnt_w[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("mid_rst_done", {31'd0, done_w[0]}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy_w[0]}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 32'd0);
    chk("post_rst_count", {29'd0, cnt_w[0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Parametrised UART transmitter with a built-in transmit FIFO, configurable word length, optional parity and configurable stop length. Transmit data enters through a valid/ready handshake and is serialised LSB-first on `tx_o`, using an externally generated oversampling tick. Consecutive words are sent back-to-back with no idle gap. The block sits between a bus-side producer and the shared baud-tick generator, and replaces the fixed 8N1 transmitter in new designs.

## Interface

**Parameters**
- `DataWidth`, default 8: data bits per frame; legal range 5..9.
- `Oversample`, default 16: sample ticks per start, data or parity bit; legal range 8..32.
- `StopBitTicks`, default 16: sample ticks in the stop interval (16/24/32 gives 1/1.5/2 stop bits at Oversample=16); must be ≥ 1.
- `ParityEn`, default 0: 1 inserts a parity bit after the data bits.
- `ParityOdd`, default 0: 0 selects even parity, 1 selects odd; ignored when ParityEn=0.
- `FifoDepth`, default 4: FIFO entries; power of two, ≥ 2.

**Ports**
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `sample_tick_i` in 1: one-clock oversampling tick.
- `din_i` in DataWidth: word to transmit.
- `din_valid_i` in 1: producer offers `din_i`.
- `din_ready_o` out 1: FIFO can accept a word; equals (count < FifoDepth).
- `fifo_count_o` out $clog2(FifoDepth)+1: current FIFO occupancy.
- `tx_o` out 1: serial line, registered, idle high.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `tx_done_tick_o` out 1: one-clock pulse at the end of each frame's stop interval.

## Operation

- **FIFO**
  - A push occurs on any clock where `din_valid_i && din_ready_o`.
  - A pop is performed by the FSM on frame load.
  - A simultaneous push and pop leaves the count unchanged.
  - A push while full is impossible because ready is low.
  - Read/write pointers wrap modulo FifoDepth.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. The tick counter and bit counter advance only on clocks with `sample_tick_i` = 1.
- **LOAD** (performed in IDLE, or at the end of STOP, when count ≠ 0):
  - Pop the head word into the shift register.
  - Latch parity = XOR of the data bits, inverted when ParityOdd = 1.
  - Clear the tick counter.
  - Go to START.
- **IDLE:** drive line 1. If count ≠ 0, perform LOAD.
- **START:** drive line 0. On the Oversample-th tick, clear the tick counter and bit counter, then go to DATA.
- **DATA:** drive line = shift[0]. On the Oversample-th tick, shift right, clear the tick counter and increment the bit counter. After bit DataWidth-1, go to PARITY if ParityEn, else go to STOP.
- **PARITY:** drive line = latched parity bit. After Oversample ticks, go to STOP.
- **STOP:** drive line 1. On the StopBitTicks-th tick:
  - Pulse `tx_done_tick_o`.
  - If count ≠ 0, perform LOAD (go to START directly).
  - Otherwise go to IDLE.
- **Frame length** = Oversample × (1 + DataWidth + ParityEn) + StopBitTicks ticks.
- **Tick counter width** is $clog2 of max(Oversample, StopBitTicks); the counter never wraps, because it is cleared on each bit end.

## Timing

- **Reset values:** `tx_o`=1, `busy_o`=0, `tx_done_tick_o`=0, `din_ready_o`=1, `fifo_count_o`=0; state IDLE; FIFO empty.
- **Output registration:** `tx_o` is registered from the current state's line value, so it lags each state change by one clock.
- **Start latency:** push accepted at edge E0, count=1 after E0, IDLE pop at E1 (state=START), `tx_o` falls at E2.
- **Done pulse:** `tx_done_tick_o` is combinational from state and counters. It is high during the clock in which the final stop tick is consumed, and never at any other time.
- **Back-to-back frames:** `tx_o` goes from stop high to start low one clock after the done pulse, with no extra idle ticks.
- **Push during LOAD:** a word pushed in the same clock as a LOAD from a non-empty FIFO is stored behind the head; order is preserved.
- **Reset mid-frame:**
  - `tx_o` goes to 1 immediately (asynchronous).
  - The FIFO is flushed, with no `tx_done_tick_o`.
  - The partially sent frame is abandoned.
- **Tick-free operation:** with `sample_tick_i` held low, state and counters freeze and `tx_o` holds; FIFO pushes still proceed.

## Test plan

- **8N1, byte 0xA5:** defaults, tick every 4th clock, push 0xA5 → line is 0,1,0,1,0,0,1,0,1 then stop 1. Each bit is 16 ticks; a single done pulse arrives 160 ticks after the start tick.
- **Even parity:** ParityEn=1, ParityOdd=0, push 0x07 → parity bit 1. With ParityOdd=1 → parity bit 0. Frame is 176 ticks.
- **Back-to-back and full FIFO:**
  - With FifoDepth=4, push 6 words (0x11..0x16) on consecutive clocks → `din_ready_o` drops once count=4 and the 6th word waits.
  - Frames follow with no idle gap; 6 done pulses arrive in order 0x11..0x16.
  - `busy_o` falls only after the last stop.
- **1.5 stop bits:** StopBitTicks=24 → stop interval is exactly 24 ticks, and the next start begins on the clock after the done pulse.
- **Five data bits:** DataWidth=5, push 0x1F → 5 high data bits; frame is 16×6+16 = 112 ticks.
- **Reset mid-frame:** assert `rst_i` during DATA bit 3 with 2 words queued → `tx_o`=1 immediately, `fifo_count_o`=0, no done pulse. After release, the bench confirms the line stays idle with no queued data.
